// File: rtl/diagonal_scan.sv
// Sequential diagonal run counter for a Connect Four board.
// Walks TL, TR, BL and BR from the dropped piece through a one-cycle-latency board RAM.
module diagonal_scan #(
    parameter int COLS   = 7,
    parameter int ROWS   = 6,
    parameter int MAXRUN = 3
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       start,
    input  logic       player,
    input  logic [2:0] location,
    input  logic [2:0] height,
    output logic       rd_en,
    output logic [2:0] rd_col,
    output logic [2:0] rd_row,
    input  logic [1:0] rd_data,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [2:0] dia_TL,
    output logic [2:0] dia_TR,
    output logic [2:0] dia_BL,
    output logic [2:0] dia_BR
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_CHECK = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [1:0] DIR_TL = 2'd0;
    localparam logic [1:0] DIR_BR = 2'd3;

    localparam logic [3:0]        COL_LIM  = 4'(COLS);
    localparam logic [3:0]        ROW_LIM  = 4'(ROWS);
    localparam logic signed [4:0] COL_MAX  = 5'(COLS - 1);
    localparam logic signed [4:0] ROW_MAX  = 5'(ROWS - 1);
    localparam logic [1:0]        STEP_MAX = 2'(MAXRUN);
    localparam logic [2:0]        RUN_MAX  = 3'(MAXRUN);

    logic [1:0]      state;
    logic [1:0]      dir;
    logic [1:0]      step;
    logic            ply;
    logic [2:0]      loc;
    logic [2:0]      hgt;
    logic            err;
    logic [3:0][2:0] cnt;

    logic signed [4:0] step_s;
    logic signed [4:0] tgt_col;
    logic signed [4:0] tgt_row;
    logic              tgt_ok;
    logic              match;
    logic              last_dir;

    function automatic logic in_range(input logic signed [4:0] v, input logic signed [4:0] hi);
        return (v >= 5'sd0) && (v <= hi);
    endfunction

    function automatic logic [2:0] sat_inc(input logic [2:0] v);
        return (v >= RUN_MAX) ? RUN_MAX : v + 3'd1;
    endfunction

    // Direction bit 0 selects column sign (TR/BR go right), bit 1 selects row sign (BL/BR go down).
    always_comb begin
        step_s   = signed'({3'b000, step});
        tgt_col  = signed'({2'b00, loc}) + (dir[0] ? step_s : -step_s);
        tgt_row  = signed'({2'b00, hgt}) + (dir[1] ? -step_s : step_s);
        tgt_ok   = in_range(tgt_col, COL_MAX) && in_range(tgt_row, ROW_MAX);
        match    = (rd_data == {ply, ~ply});
        last_dir = (dir == DIR_BR);
    end

    always_comb begin
        rd_en  = (state == S_ISSUE) && tgt_ok;
        rd_col = rd_en ? tgt_col[2:0] : 3'd0;
        rd_row = rd_en ? tgt_row[2:0] : 3'd0;
        busy   = (state != S_IDLE);
        done   = (state == S_DONE);
        error  = err;
        dia_TL = cnt[0];
        dia_TR = cnt[1];
        dia_BL = cnt[2];
        dia_BR = cnt[3];
    end

    // Origin and player are data-only: never observable while idle, so they skip reset.
    always_ff @(posedge clock) begin
        if (start && (state == S_IDLE || state == S_DONE)) begin
            ply <= player;
            loc <= location;
            hgt <= height;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state <= S_IDLE;
            dir   <= DIR_TL;
            step  <= 2'd1;
            err   <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    state <= S_IDLE;
                    if (start) begin
                        cnt  <= '0;
                        dir  <= DIR_TL;
                        step <= 2'd1;
                        if (({1'b0, location} >= COL_LIM) || ({1'b0, height} >= ROW_LIM)) begin
                            err   <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            err   <= 1'b0;
                            state <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (tgt_ok) begin
                        state <= S_CHECK;
                    end else begin
                        step <= 2'd1;
                        if (last_dir) begin
                            state <= S_DONE;
                        end else begin
                            dir   <= dir + 2'd1;
                            state <= S_ISSUE;
                        end
                    end
                end
                S_CHECK: begin
                    if (match) begin
                        cnt[dir] <= sat_inc(cnt[dir]);
                    end
                    if (match && (step != STEP_MAX)) begin
                        step  <= step + 2'd1;
                        state <= S_ISSUE;
                    end else begin
                        step <= 2'd1;
                        if (last_dir) begin
                            state <= S_DONE;
                        end else begin
                            dir   <= dir + 2'd1;
                            state <= S_ISSUE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
